// File: rtl/ram_access_arbiter.sv
// Burst-granting arbiter sharing one RAM port between the ADMA engine and the host path.
// Round-robin by default; define RAM_ARB_HOST_PRIO_EN for fixed host priority on ties.
module ram_access_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 16,
    parameter int BEAT_BYTES = 4
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [4:0]        dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_grant,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    input  logic              host_req,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [4:0]        host_len,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_grant,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              ram_write,
    output logic              ram_read,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic OWN_DMA  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    state_t            state_r;
    state_t            state_s;
    logic              owner_r;
    logic              last_owner_r;
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [4:0]        len_r;
    logic [4:0]        beat_r;
    logic              rd_ack_r;
    logic              pick_s;
    logic              any_req_s;

    // Zero-length requests still move one beat; oversize requests are clipped.
    function automatic logic [4:0] eff_len(input logic [4:0] len);
        logic [4:0] res;
        if (len == 5'd0) begin
            res = 5'd1;
        end else if (len > 5'(MAX_BURST)) begin
            res = 5'(MAX_BURST);
        end else begin
            res = len;
        end
        return res;
    endfunction

    assign any_req_s = dma_req | host_req;

    // Arbitration winner among the requests sampled in IDLE.
    always_comb begin
        pick_s = OWN_DMA;
`ifdef RAM_ARB_HOST_PRIO_EN
        if (host_req) begin
            pick_s = OWN_HOST;
        end else begin
            pick_s = OWN_DMA;
        end
`else
        if (dma_req && host_req) begin
            pick_s = ~last_owner_r;
        end else if (host_req) begin
            pick_s = OWN_HOST;
        end else begin
            pick_s = OWN_DMA;
        end
`endif
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = ST_BURST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (beat_r == (len_r - 5'd1)) begin
                    state_s = write_r ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_s = ST_BURST;
                end
            end
            ST_DRAIN: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register plus burst context latched at grant time.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_DMA;
            last_owner_r <= OWN_HOST;
            write_r      <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            len_r        <= 5'd0;
            beat_r       <= 5'd0;
            rd_ack_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            // Read data comes back one cycle after each read strobe.
            rd_ack_r <= (state_r == ST_BURST) && !write_r;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        owner_r      <= pick_s;
                        last_owner_r <= pick_s;
                        write_r      <= pick_s ? host_write : dma_write;
                        addr_r       <= pick_s ? host_address : dma_address;
                        len_r        <= eff_len(pick_s ? host_len : dma_len);
                        beat_r       <= 5'd0;
                    end
                end
                ST_BURST: begin
                    beat_r <= beat_r + 5'd1;
                    addr_r <= addr_r + ADDR_W'(BEAT_BYTES);
                end
                default: begin
                    beat_r <= beat_r;
                end
            endcase
        end
    end

    logic in_burst_s;
    logic grant_s;
    logic beat_ack_s;
    logic wr_strobe_s;

    assign in_burst_s  = (state_r == ST_BURST);
    assign grant_s     = (state_r == ST_BURST) || (state_r == ST_DRAIN);
    assign wr_strobe_s = in_burst_s && write_r;
    assign beat_ack_s  = wr_strobe_s || rd_ack_r;

    assign ram_write    = wr_strobe_s;
    assign ram_read     = in_burst_s && !write_r;
    assign ram_address  = in_burst_s ? addr_r : {ADDR_W{1'b0}};
    assign ram_data_out = wr_strobe_s ? (owner_r ? host_wdata : dma_wdata) : {DATA_W{1'b0}};
    assign busy         = (state_r != ST_IDLE);

    assign dma_grant  = grant_s && (owner_r == OWN_DMA);
    assign dma_ack    = beat_ack_s && (owner_r == OWN_DMA);
    assign dma_rdata  = (rd_ack_r && (owner_r == OWN_DMA)) ? ram_data_in : {DATA_W{1'b0}};
    assign host_grant = grant_s && (owner_r == OWN_HOST);
    assign host_ack   = beat_ack_s && (owner_r == OWN_HOST);
    assign host_rdata = (rd_ack_r && (owner_r == OWN_HOST)) ? ram_data_in : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: directed bursts push expected RAM beats and
// acks into queues; a negedge monitor pops and compares whenever the DUT strobes or acks.
module tb_ram_access_arbiter;

`ifdef RAM_ARB_HOST_PRIO_EN
    localparam bit HOST_PRIO = 1'b1;
`else
    localparam bit HOST_PRIO = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_L;
    logic        dma_req, dma_write, host_req, host_write;
    logic [63:0] dma_address, host_address;
    logic [4:0]  dma_len, host_len;
    logic [31:0] dma_wdata, host_wdata;
    logic        dma_grant, dma_ack, host_grant, host_ack;
    logic [31:0] dma_rdata, host_rdata;
    logic [63:0] ram_address;
    logic [31:0] ram_data_out, ram_data_in;
    logic        ram_write, ram_read, busy;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        who;
        logic        wr;
        logic [63:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t ram_q[$];
    ev_t ack_q[$];
    ev_t mon_e;
    logic [31:0] mem [logic [63:0]];

    ram_access_arbiter dut (
        .CLK(CLK), .RESET_L(RESET_L),
        .dma_req(dma_req), .dma_write(dma_write), .dma_address(dma_address),
        .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_grant(dma_grant),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .host_req(host_req), .host_write(host_write), .host_address(host_address),
        .host_len(host_len), .host_wdata(host_wdata), .host_grant(host_grant),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .ram_address(ram_address), .ram_data_out(ram_data_out),
        .ram_write(ram_write), .ram_read(ram_read), .ram_data_in(ram_data_in),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ram_val(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return mem.exists(a) ? mem[a] : (lo ^ 32'hC0DE_0000);
    endfunction

    // Synchronous RAM model: read data appears the cycle after the read strobe.
    always @(posedge CLK) begin
        if (ram_write) mem[ram_address] = ram_data_out;
        if (ram_read) ram_data_in <= ram_val(ram_address);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic who, input logic wr, input logic [63:0] a, input logic [31:0] d);
        ev_t e;
        e.who = who; e.wr = wr; e.addr = a; e.data = d;
        ram_q.push_back(e);
        ack_q.push_back(e);
    endtask

    // Monitor: compare every strobe and ack against the scoreboard, plus port invariants.
    always @(negedge CLK) begin
        chk("excl_strobe", ram_write & ram_read, 1'b0);
        chk("excl_grant", dma_grant & host_grant, 1'b0);
        if (ram_write | ram_read) begin
            compared++;
            if (ram_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_ram: got addr %h with no expected beat", ram_address);
            end else begin
                mon_e = ram_q.pop_front();
                chk("ram_dir", ram_write, mon_e.wr);
                chk("ram_addr", ram_address, mon_e.addr);
                if (mon_e.wr) chk("ram_wdata", ram_data_out, mon_e.data);
                chk("owner_grant", mon_e.who ? host_grant : dma_grant, 1'b1);
            end
        end else begin
            chk("idle_addr", ram_address, 64'd0);
            chk("idle_wdata", ram_data_out, 32'd0);
        end
        if (dma_ack | host_ack) begin
            compared++;
            if (ack_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_ack: got dma %b host %b with no expected ack", dma_ack, host_ack);
            end else begin
                mon_e = ack_q.pop_front();
                chk("dual_ack", dma_ack & host_ack, 1'b0);
                chk("ack_owner", host_ack, mon_e.who);
                chk("ack_grant", mon_e.who ? host_grant : dma_grant, 1'b1);
                if (!mon_e.wr) chk("ack_rdata", mon_e.who ? host_rdata : dma_rdata, mon_e.data);
                chk("nonowner_rdata", mon_e.who ? dma_rdata : host_rdata, 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_dma_grant"}, dma_grant, 1'b0);
        chk({tag, "_dma_ack"}, dma_ack, 1'b0);
        chk({tag, "_dma_rdata"}, dma_rdata, 32'd0);
        chk({tag, "_host_grant"}, host_grant, 1'b0);
        chk({tag, "_host_ack"}, host_ack, 1'b0);
        chk({tag, "_host_rdata"}, host_rdata, 32'd0);
        chk({tag, "_ram_addr"}, ram_address, 64'd0);
        chk({tag, "_ram_dout"}, ram_data_out, 32'd0);
        chk({tag, "_ram_write"}, ram_write, 1'b0);
        chk({tag, "_ram_read"}, ram_read, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        RESET_L = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET_L = 1'b1;
    endtask

    // One requester, one burst; caller is at #1 after a posedge with the DUT idle.
    task automatic run_burst(input logic who, input logic wr, input logic [63:0] base,
                             input logic [4:0] len, input logic [31:0] wbase, input int n);
        int lat;
        logic g;
        for (int k = 0; k < n; k++) begin
            logic [63:0] a;
            a = base + 64'(4 * k);
            push_ev(who, wr, a, wr ? (wbase + 32'(4 * k)) : ram_val(a));
        end
        if (who) begin
            host_req = 1'b1; host_write = wr; host_address = base; host_len = len; host_wdata = wbase;
        end else begin
            dma_req = 1'b1; dma_write = wr; dma_address = base; dma_len = len; dma_wdata = wbase;
        end
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
            g = who ? host_grant : dma_grant;
        end while (!g && lat < 20);
        chk("grant_latency", 64'(lat), 64'd1);
        dma_req = 1'b0; host_req = 1'b0;
        dma_address = 64'hDEAD; host_address = 64'hBEEF;
        if (!g) return;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #1;
            if (who) host_wdata = wbase + 32'(4 * (k + 1));
            else dma_wdata = wbase + 32'(4 * (k + 1));
        end
        if (!wr) begin
            @(posedge CLK); #1;
        end
        chk("grant_drop", who ? host_grant : dma_grant, 1'b0);
        chk("busy_idle", busy, 1'b0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acks, cyc, dcnt, hcnt;
        logic d, h, who;
        RESET_L = 1'b0;
        dma_req = 1'b0; dma_write = 1'b0; dma_address = 64'd0; dma_len = 5'd0; dma_wdata = 32'd0;
        host_req = 1'b0; host_write = 1'b0; host_address = 64'd0; host_len = 5'd0; host_wdata = 32'd0;
        ram_data_in = 32'd0;
        for (int i = 0; i < 4; i++) mem[64'd512 + 64'(4 * i)] = 32'hA0 + 32'(i);
        #2 check_all_zero("reset");
        repeat (2) @(posedge CLK);
        #1 RESET_L = 1'b1;
        @(posedge CLK); #1;

        run_burst(1'b0, 1'b1, 64'd0, 5'd8, 32'd4, 8);
        run_burst(1'b1, 1'b0, 64'd512, 5'd4, 32'd0, 4);
        run_burst(1'b1, 1'b0, 64'd600, 5'd0, 32'd0, 1);
        run_burst(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 5'd4, 32'h77, 4);
        run_burst(1'b1, 1'b1, 64'h4000, 5'd31, 32'h900, 16);

        // Reset during beat 3 of an 8-beat write: only beats 0..2 may be seen.
        for (int k = 0; k < 3; k++) push_ev(1'b0, 1'b1, 64'h3000 + 64'(4 * k), 32'h50 + 32'(4 * k));
        dma_req = 1'b1; dma_write = 1'b1; dma_address = 64'h3000; dma_len = 5'd8; dma_wdata = 32'h50;
        @(posedge CLK); #1;
        chk("rst_test_grant", dma_grant, 1'b1);
        dma_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            dma_wdata = 32'h50 + 32'(4 * (k + 1));
        end
        #1 RESET_L = 1'b0;
        #1 check_all_zero("midreset");
        repeat (2) @(posedge CLK);
        #1 RESET_L = 1'b1;
        @(posedge CLK); #1;
        run_burst(1'b1, 1'b0, 64'h700, 5'd1, 32'd0, 1);

        // Both requesters held high after a fresh reset, two beats each.
        do_reset();
        @(posedge CLK); #1;
        dcnt = 0; hcnt = 0;
        for (int b = 0; b < 4; b++) begin
            who = HOST_PRIO ? 1'b1 : ((b % 2) == 1);
            for (int k = 0; k < 2; k++) begin
                if (who) begin
                    push_ev(1'b1, 1'b1, 64'h2000 + 64'(4 * k), 32'h200 + 32'(4 * hcnt));
                    hcnt++;
                end else begin
                    push_ev(1'b0, 1'b1, 64'h1000 + 64'(4 * k), 32'h100 + 32'(4 * dcnt));
                    dcnt++;
                end
            end
        end
        dma_req = 1'b1; dma_write = 1'b1; dma_address = 64'h1000; dma_len = 5'd2; dma_wdata = 32'h100;
        host_req = 1'b1; host_write = 1'b1; host_address = 64'h2000; host_len = 5'd2; host_wdata = 32'h200;
        acks = 0; cyc = 0;
        while (acks < 8 && cyc < 60) begin
            @(negedge CLK);
            d = dma_ack; h = host_ack;
            @(posedge CLK); #1;
            cyc++;
            if (d) begin dma_wdata = dma_wdata + 32'd4; acks++; end
            if (h) begin host_wdata = host_wdata + 32'd4; acks++; end
        end
        dma_req = 1'b0; host_req = 1'b0;
        chk("arb_ack_count", 64'(acks), 64'd8);

        repeat (4) @(posedge CLK);
        #1;
        chk("ram_q_empty", 64'(ram_q.size()), 64'd0);
        chk("ack_q_empty", 64'(ack_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Shares the single system RAM port (64-bit byte address, 32-bit data, separate write/read strobes) between two requesters: the ADMA engine and the host register-side access path.
- Grants whole bursts. Round-robin by default.
- Generates incrementing beat addresses and sequences the RAM strobes.
- Returns per-beat acknowledges and read data to the owning requester.
- Sits between the ADMA datapath and the RAM model/macro.

Parameters:
ADDR_W, 64, RAM byte-address width
DATA_W, 32, RAM data width
MAX_BURST, 16, maximum beats per grant
BEAT_BYTES, 4, address increment per beat

Ports:
CLK  in  1  system clock, rising edge
RESET_L  in  1  asynchronous active-low reset
dma_req  in  1  DMA burst request
dma_write  in  1  1=write burst, 0=read burst
dma_address  in  ADDR_W  burst base address
dma_len  in  5  beats requested; 0 treated as 1; values above MAX_BURST clipped to MAX_BURST
dma_wdata  in  DATA_W  current write beat data
dma_grant  out  1  DMA owns RAM
dma_ack  out  1  one pulse per completed beat
dma_rdata  out  DATA_W  read data, valid with dma_ack
host_req, host_write, host_address, host_len, host_wdata, host_grant, host_ack, host_rdata: same as dma_* for the host
ram_address  out  ADDR_W  RAM address
ram_data_out  out  DATA_W  RAM write data
ram_write  out  1  RAM write strobe
ram_read  out  1  RAM read strobe
ram_data_in  in  DATA_W  RAM read data, one cycle after ram_read
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, RESET_L=0):
  - All outputs go to 0 immediately; state=IDLE; last_owner=HOST, so the first tie goes to DMA.
  - Reset asserted mid-burst aborts it with no further acks.
- States: IDLE, BURST, DRAIN.
- IDLE: at each edge, sample the requests.
  - One request: that requester wins.
  - Both requests: the requester that is not last_owner wins.
  - On a win: latch owner, direction, base address and effective length; set last_owner=owner; go to BURST.
- BURST (lasts len cycles):
  - owner_grant=1.
  - Beat k: ram_address = base + k*BEAT_BYTES, modulo 2^ADDR_W (wraps silently).
  - Write burst:
    - ram_write=1 and ram_data_out = owner wdata (combinational mux).
    - owner_ack=1 in the same cycle.
    - The requester advances wdata on the edge where ack=1. Beat-0 data must be valid while req is high.
  - Read burst:
    - ram_read=1.
    - owner_ack=1 and owner_rdata=ram_data_in one cycle after each read beat (registered).
  - After the last beat: write burst goes to IDLE; read burst goes to DRAIN.
- DRAIN: one cycle; the final read ack and data are presented, grant is held; then IDLE.
- Grant is held from the first beat through the last ack, and drops in the following cycle.
- Grant latency: 1 cycle from req sampled in IDLE.
- There is at least one IDLE cycle between consecutive grants.
- req deassertion during BURST/DRAIN is ignored: the latched burst always completes.
- The non-owner's grant, ack and rdata stay 0. Its req stays pending until the return to IDLE.
- The non-owner's address, length and wdata changes have no effect during a burst.
- ram_write and ram_read are never both 1.
- ram_address and ram_data_out are 0 when no strobe is active.

Optional Feature:
RAM_ARB_HOST_PRIO_EN
- Defined: fixed priority. Host always wins simultaneous requests in IDLE; last_owner is ignored.
- Undefined: round-robin as above.
- All other behaviour is identical in both cases.

Test Plan:
- Reset: assert RESET_L=0 mid-clock-phase → all outputs 0 with no clock edge; busy=0.
- DMA write, base 0x0, len 8, data 4,8,…,32:
  - 8 ram_write cycles, addresses 0x0..0x1C, ram_data_out 4..32.
  - 8 dma_ack pulses; dma_grant drops after the 8th.
  - host_grant=0 throughout.
- Host read, base 512, len 4, RAM returns 0xA0..0xA3:
  - ram_read high 4 cycles, addresses 512,516,520,524.
  - host_ack pulses lag by one cycle, with rdata 0xA0..0xA3; DRAIN cycle carries 0xA3.
  - len 0 variant → exactly 1 beat.
- Both requests held high after reset, len 2 each:
  - Order is DMA, host, DMA, host.
  - With RAM_ARB_HOST_PRIO_EN defined: host repeatedly, DMA starved.
- Wrap: base 0xFFFF_FFFF_FFFF_FFF8, len 4 → addresses …FFF8, …FFFC, 0x0, 0x4.
- Reset at beat 3 of a len-8 write:
  - Strobes drop immediately; no further acks.
  - After release, a new host len-1 read is granted 1 cycle after req.
